// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Brings up the video/pixel PLL from its reference clock.
//               The PLL is held in reset for a fixed time. The block then
//               waits for lock and checks that lock stays stable. After
//               that it holds the downstream core in reset for a fixed
//               delay before releasing it. Loss of lock, lock timeout or a
//               restart request all cause a new sequence. Saturating
//               counters record timeouts and loss-of-lock events.
// Ports       :
//   refclk      in   controller clock (free-running PLL reference)
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   restart_req in   single-cycle request for a full re-sequence
//   pll_rst     out  reset to the PLL
//   core_rst    out  active-high reset for logic on PLL output clocks
//   ready       out  high only while running with qualified lock
//   state       out  encoded FSM state (debug)
//   retry_count out  saturating count of lock timeouts
//   lol_count   out  saturating count of loss-of-lock events in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int CORE_RST_DELAY      = 32,
  parameter int CNT_W               = 21
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] lol_count
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // The lk_s=1 cycle that moves WAIT_LOCK to STABLE counts as the first
  // stable cycle. STABLE therefore ends one count early. This keeps the
  // lock-to-release latency equal to LOCK_STABLE_CYCLES + CORE_RST_DELAY.
  // When only one stable cycle is required, STABLE is skipped.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
      CNT_W'((LOCK_STABLE_CYCLES > 1) ? (LOCK_STABLE_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(CORE_RST_DELAY - 1);
  localparam bit               STB_SKIP = (LOCK_STABLE_CYCLES <= 1);

  state_t           fsm;
  logic [CNT_W-1:0] cnt;
  logic             sync_ff;
  logic             lk_s;

  // Two-flop synchronizer for the asynchronous lock indicator
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_ff <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      sync_ff <= pll_locked;
      lk_s    <= sync_ff;
    end
  end

  // Sequencer. Outputs are set on each state transition and hold in
  // between. Every transition clears cnt, so cnt never wraps.
  always_ff @(posedge refclk) begin
    if (rst) begin
      fsm         <= RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      core_rst    <= 1'b1;
      ready       <= 1'b0;
      retry_count <= 8'd0;
      lol_count   <= 8'd0;
    end else begin
      case (fsm)
        RESET_PLL: begin
          // restart_req is ignored here; the PLL is already being reset
          if (cnt == RST_LAST) begin
            fsm     <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (restart_req) begin
            fsm     <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end else if (lk_s) begin
            fsm <= STB_SKIP ? RELEASE : STABLE;
            cnt <= '0;
          end else if (cnt == TMO_LAST) begin
            fsm     <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STABLE: begin
          if (restart_req) begin
            fsm     <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end else if (!lk_s) begin
            fsm <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == STB_LAST) begin
            fsm <= RELEASE;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (restart_req) begin
            fsm     <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end else if (!lk_s) begin
            fsm <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == REL_LAST) begin
            fsm      <= RUN;
            cnt      <= '0;
            core_rst <= 1'b0;
            ready    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          if (restart_req || !lk_s) begin
            fsm      <= RESET_PLL;
            cnt      <= '0;
            pll_rst  <= 1'b1;
            core_rst <= 1'b1;
            ready    <= 1'b0;
            // A restart that coincides with loss of lock is not counted
            if (!restart_req && lol_count != 8'hFF)
              lol_count <= lol_count + 8'd1;
          end
        end

        default: begin
          fsm      <= RESET_PLL;
          cnt      <= '0;
          pll_rst  <= 1'b1;
          core_rst <= 1'b1;
          ready    <= 1'b0;
        end
      endcase
    end
  end

  assign state = fsm;

endmodule
`default_nettype wire
